// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch stage: default geometry,
// RV32I opcodes used by the predictor, FSM states and small helpers.
`timescale 1ns/1ps
package ifetch_pkg;

    localparam int ICACHE_IDX_DEF = 6;   // 64 one-word icache lines
    localparam int BHT_IDX_DEF    = 8;   // 256 two-bit counters

    localparam logic [6:0] OPCODE_JAL  = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR = 7'b1100111;
    localparam logic [6:0] OPCODE_BR   = 7'b1100011;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_WAIT_MEM = 1'b1
    } fetch_state_e;

    // J-type immediate, sign-extended to 32 bits
    function automatic logic [31:0] imm_j(input logic [31:0] i);
        return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    // B-type immediate, sign-extended to 32 bits
    function automatic logic [31:0] imm_b(input logic [31:0] i);
        return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    // Saturating two-bit counter step
    function automatic logic [1:0] bht_step(input logic [1:0] c, input logic up);
        logic [1:0] r;
        r = c;
        if (up && c != 2'b11)
            r = c + 2'b01;
        else if (!up && c != 2'b00)
            r = c - 2'b01;
        return r;
    endfunction

endpackage

// File: rtl/ifetch_icache.sv
// Direct-mapped instruction cache with one-word lines: combinational
// hit/data lookup and a single write port used by refills.
`timescale 1ns/1ps
module icache
    import ifetch_pkg::*;
#(
    parameter int IDX_W = ICACHE_IDX_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] rd_addr,   // word address (pc[31:2])
    output logic        hit,
    output logic [31:0] rd_data,
    input  logic        wr_en,
    input  logic [29:0] wr_addr,   // word address of the refilled line
    input  logic [31:0] wr_data
);
    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;

    logic [LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic [TAG_W-1:0] rd_tag, wr_tag;

    assign rd_idx = rd_addr[IDX_W-1:0];
    assign rd_tag = rd_addr[29:IDX_W];
    assign wr_idx = wr_addr[IDX_W-1:0];
    assign wr_tag = wr_addr[29:IDX_W];

    assign hit     = valid_q[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    assign rd_data = data_mem[rd_idx];

    // Next valid vector: a refill marks its line valid
    always_comb begin
        valid_d = valid_q;
        if (wr_en)
            valid_d[wr_idx] = 1'b1;
    end

    // Valid bits; reset invalidates the whole cache
    always_ff @(posedge clk) begin
        if (rst)
            valid_q <= '0;
        else
            valid_q <= valid_d;
    end

    // Tag and data storage, written only by refills
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: owns the fetch PC, the icache refill FSM and a
// bimodal branch predictor; issues at most one instruction per cycle.
`timescale 1ns/1ps
module ifetch
    import ifetch_pkg::*;
#(
    parameter int ICACHE_IDX = ICACHE_IDX_DEF,
    parameter int BHT_IDX    = BHT_IDX_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rs_nxt_full,
    input  logic        lsb_nxt_full,
    input  logic        rob_nxt_full,
    input  logic        rollback,
    input  logic [31:0] rob_set_pc,
    input  logic        rob_br,
    input  logic [31:0] rob_br_pc,
    input  logic        rob_br_jump,
    output logic        mem_inst_en,
    output logic [31:0] mem_inst_addr,
    input  logic        mem_inst_rdy,
    input  logic [31:0] mem_inst,
    output logic        inst_rdy,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_pred_jump
);
    localparam int BHT_N = 1 << BHT_IDX;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         inst_rdy_q, inst_rdy_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  inst_pc_q, inst_pc_d;
    logic         pred_q, pred_d;
    logic         mem_en_q, mem_en_d;
    logic [31:0]  mem_addr_q, mem_addr_d;

    logic         stall;
    logic         ic_hit;
    logic [31:0]  ic_data;
    logic         fill_we;
    logic         fill_en;

    logic [1:0]         bht_q [BHT_N];
    logic [BHT_IDX-1:0] bht_rd_idx, bht_wr_idx;
    logic [1:0]         bht_ctr;
    logic               pred_taken;
    logic [31:0]        pred_next;

    // Bits of the committed-branch PC that do not select a BHT entry
    logic unused_rob_br_pc;
    assign unused_rob_br_pc = ^{rob_br_pc[31:BHT_IDX+2], rob_br_pc[1:0]};

    assign stall      = rs_nxt_full | lsb_nxt_full | rob_nxt_full;
    assign bht_rd_idx = pc_q[BHT_IDX+1:2];
    assign bht_wr_idx = rob_br_pc[BHT_IDX+1:2];
    assign bht_ctr    = bht_q[bht_rd_idx];

    // Refill writes obey the global freeze and lose to reset
    assign fill_en = fill_we & rdy & ~rst;

    icache #(.IDX_W(ICACHE_IDX)) u_icache (
        .clk     (clk),
        .rst     (rst),
        .rd_addr (pc_q[31:2]),
        .hit     (ic_hit),
        .rd_data (ic_data),
        .wr_en   (fill_en),
        .wr_addr (mem_addr_q[31:2]),
        .wr_data (mem_inst)
    );

    // Predict direction and next PC for the word currently looked up
    always_comb begin
        pred_taken = 1'b0;
        pred_next  = pc_q + 32'd4;
        case (ic_data[6:0])
            OPCODE_JAL: begin
                pred_taken = 1'b1;
                pred_next  = pc_q + imm_j(ic_data);
            end
            OPCODE_BR: begin
                if (bht_ctr[1]) begin
                    pred_taken = 1'b1;
                    pred_next  = pc_q + imm_b(ic_data);
                end
            end
            OPCODE_JALR: begin
                // Register target is unknown here; fall through to pc+4
                pred_taken = 1'b0;
            end
            default: begin
                pred_taken = 1'b0;
            end
        endcase
    end

    // Fetch FSM next state: rollback redirects first, refills always finish
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_rdy_d = 1'b0;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        pred_d     = pred_q;
        mem_en_d   = mem_en_q;
        mem_addr_d = mem_addr_q;
        fill_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rollback) begin
                    pc_d = rob_set_pc;
                end else if (!ic_hit) begin
                    mem_en_d   = 1'b1;
                    mem_addr_d = pc_q;
                    state_d    = S_WAIT_MEM;
                end else if (!stall) begin
                    inst_rdy_d = 1'b1;
                    inst_d     = ic_data;
                    inst_pc_d  = pc_q;
                    pred_d     = pred_taken;
                    pc_d       = pred_next;
                end
            end
            S_WAIT_MEM: begin
                if (rollback)
                    pc_d = rob_set_pc;
                if (mem_inst_rdy) begin
                    fill_we  = 1'b1;
                    mem_en_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Fetch state registers, frozen while rdy is low
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            inst_rdy_q <= 1'b0;
            inst_q     <= '0;
            inst_pc_q  <= '0;
            pred_q     <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
        end else if (rdy) begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_rdy_q <= inst_rdy_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
            pred_q     <= pred_d;
            mem_en_q   <= mem_en_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // BHT counters: weakly not-taken at reset, trained by committed branches
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_N; i++)
                bht_q[i] <= 2'b01;
        end else if (rdy && rob_br) begin
            bht_q[bht_wr_idx] <= bht_step(bht_q[bht_wr_idx], rob_br_jump);
        end
    end

    assign mem_inst_en    = mem_en_q;
    assign mem_inst_addr  = mem_addr_q;
    assign inst_rdy       = inst_rdy_q;
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign inst_pred_jump = pred_q;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch with a fixed-latency instruction memory model.
`timescale 1ns/1ps
module tb_ifetch;

    localparam int MEM_LAT = 3;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        rs_nxt_full, lsb_nxt_full, rob_nxt_full;
    logic        rollback;
    logic [31:0] rob_set_pc;
    logic        rob_br;
    logic [31:0] rob_br_pc;
    logic        rob_br_jump;
    logic        mem_inst_en;
    logic [31:0] mem_inst_addr;
    logic        mem_inst_rdy;
    logic [31:0] mem_inst;
    logic        inst_rdy;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_pred_jump;

    int n_checks = 0;
    int n_errors = 0;

    ifetch dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .rs_nxt_full    (rs_nxt_full),
        .lsb_nxt_full   (lsb_nxt_full),
        .rob_nxt_full   (rob_nxt_full),
        .rollback       (rollback),
        .rob_set_pc     (rob_set_pc),
        .rob_br         (rob_br),
        .rob_br_pc      (rob_br_pc),
        .rob_br_jump    (rob_br_jump),
        .mem_inst_en    (mem_inst_en),
        .mem_inst_addr  (mem_inst_addr),
        .mem_inst_rdy   (mem_inst_rdy),
        .mem_inst       (mem_inst),
        .inst_rdy       (inst_rdy),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_pred_jump (inst_pred_jump)
    );

    always #5 clk = ~clk;

    // Program image
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0010_0093;  // addi x1,x0,1
            32'h0000_0004: return 32'h0020_0113;  // addi x2,x0,2
            32'h0000_0008: return 32'h0100_00EF;  // jal  x1,16  -> 0x18
            32'h0000_0018: return 32'h0080_006F;  // jal  x0,8   -> 0x20
            32'h0000_0020: return 32'h0000_0863;  // beq  x0,x0,16 -> 0x30
            32'h0000_0024: return 32'h0000_006F;  // jal  x0,0 (spin)
            32'h0000_0030: return 32'h0000_006F;
            32'h0000_0040: return 32'h0000_006F;
            32'h0000_0100: return 32'h0000_006F;
            32'h0000_0200: return 32'h0000_006F;
            default:       return 32'h0000_0013;  // nop
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_inst(input string tag);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(posedge clk); #1;
            if (inst_rdy) seen = 1'b1;
        end
        check({tag, "_seen"}, {31'b0, seen}, 32'd1);
    endtask

    task automatic wait_req(input string tag, input logic [31:0] addr);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(posedge clk); #1;
            if (mem_inst_en && mem_inst_addr == addr) seen = 1'b1;
        end
        check({tag, "_seen"}, {31'b0, seen}, 32'd1);
    endtask

    // Memory model: answers each request MEM_LAT cycles later with a one-cycle pulse
    initial begin
        logic [31:0] req;
        mem_inst_rdy = 1'b0;
        mem_inst     = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_inst_en && !rst) begin
                req = mem_inst_addr;
                repeat (MEM_LAT - 1) @(posedge clk);
                #1;
                mem_inst     = mem_word(req);
                mem_inst_rdy = 1'b1;
                @(posedge clk); #1;
                mem_inst_rdy = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rdy = 1'b1;
        rs_nxt_full = 1'b0; lsb_nxt_full = 1'b0; rob_nxt_full = 1'b0;
        rollback = 1'b0; rob_set_pc = '0;
        rob_br = 1'b0; rob_br_pc = '0; rob_br_jump = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_inst_rdy", {31'b0, inst_rdy}, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_pred", {31'b0, inst_pred_jump}, 32'd0);
        check("rst_mem_en", {31'b0, mem_inst_en}, 32'd0);
        check("rst_mem_addr", mem_inst_addr, 32'd0);
        rst = 1'b0;

        // Cold miss at 0x0
        @(posedge clk); #1;
        check("miss0_en", {31'b0, mem_inst_en}, 32'd1);
        check("miss0_addr", mem_inst_addr, 32'h0);
        check("miss0_no_rdy", {31'b0, inst_rdy}, 32'd0);

        wait_inst("f0");
        check("f0_pc", inst_pc, 32'h0);
        check("f0_inst", inst, 32'h0010_0093);
        check("f0_pred", {31'b0, inst_pred_jump}, 32'd0);
        @(posedge clk); #1;
        check("f0_pulse", {31'b0, inst_rdy}, 32'd0);

        wait_inst("f4");
        check("f4_pc", inst_pc, 32'h4);
        check("f4_pred", {31'b0, inst_pred_jump}, 32'd0);

        wait_inst("f8");
        check("f8_pc", inst_pc, 32'h8);
        check("f8_inst", inst, 32'h0100_00EF);
        check("f8_pred", {31'b0, inst_pred_jump}, 32'd1);

        wait_inst("f18");
        check("f18_pc", inst_pc, 32'h18);
        check("f18_pred", {31'b0, inst_pred_jump}, 32'd1);

        wait_inst("f20");
        check("f20_pc", inst_pc, 32'h20);
        check("f20_pred_weak", {31'b0, inst_pred_jump}, 32'd0);

        wait_inst("f24");
        check("f24_pc", inst_pc, 32'h24);
        check("f24_pred", {31'b0, inst_pred_jump}, 32'd1);
        @(posedge clk); #1;
        check("loop_rdy", {31'b0, inst_rdy}, 32'd1);
        check("loop_pc", inst_pc, 32'h24);

        // ROB back-pressure for three cycles
        rob_nxt_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("stall_rob_rdy", {31'b0, inst_rdy}, 32'd0);
        end
        rob_nxt_full = 1'b0;
        @(posedge clk); #1;
        check("resume_rdy", {31'b0, inst_rdy}, 32'd1);
        check("resume_pc", inst_pc, 32'h24);

        // RS and LSB back-pressure, one cycle each
        rs_nxt_full = 1'b1;
        @(posedge clk); #1;
        check("stall_rs_rdy", {31'b0, inst_rdy}, 32'd0);
        rs_nxt_full = 1'b0;
        lsb_nxt_full = 1'b1;
        @(posedge clk); #1;
        check("stall_lsb_rdy", {31'b0, inst_rdy}, 32'd0);
        lsb_nxt_full = 1'b0;
        @(posedge clk); #1;

        // Train the branch at 0x20 taken twice (01 -> 11), then re-fetch it
        rob_br = 1'b1; rob_br_pc = 32'h20; rob_br_jump = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rob_br = 1'b0;
        rollback = 1'b1; rob_set_pc = 32'h20;
        @(posedge clk); #1;
        rollback = 1'b0;
        check("rb_discard_rdy", {31'b0, inst_rdy}, 32'd0);
        @(posedge clk); #1;
        check("br_rdy", {31'b0, inst_rdy}, 32'd1);
        check("br_pc", inst_pc, 32'h20);
        check("br_inst", inst, 32'h0000_0863);
        check("br_pred_taken", {31'b0, inst_pred_jump}, 32'd1);
        @(posedge clk); #1;
        check("br_target_req", mem_inst_addr, 32'h30);
        wait_inst("f30");
        check("f30_pc", inst_pc, 32'h30);
        @(posedge clk); #1;

        // Freeze with rdy low while a rollback and not-taken commits are presented
        rdy = 1'b0;
        rollback = 1'b1; rob_set_pc = 32'h20;
        rob_br = 1'b1; rob_br_pc = 32'h20; rob_br_jump = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("frz_rdy", {31'b0, inst_rdy}, 32'd1);
            check("frz_pc", inst_pc, 32'h30);
            check("frz_mem_en", {31'b0, mem_inst_en}, 32'd0);
        end
        rdy = 1'b1;
        rob_br = 1'b0;
        @(posedge clk); #1;
        rollback = 1'b0;
        check("unfrz_rb_rdy", {31'b0, inst_rdy}, 32'd0);
        @(posedge clk); #1;
        check("unfrz_br_pc", inst_pc, 32'h20);
        check("unfrz_br_pred", {31'b0, inst_pred_jump}, 32'd1);
        @(posedge clk); #1;

        // Rollback while a refill of 0x40 is outstanding
        rollback = 1'b1; rob_set_pc = 32'h40;
        @(posedge clk); #1;
        rollback = 1'b0;
        wait_req("req40", 32'h40);
        rollback = 1'b1; rob_set_pc = 32'h100;
        @(posedge clk); #1;
        rollback = 1'b0;
        check("wm_en_held", {31'b0, mem_inst_en}, 32'd1);
        check("wm_addr_held", mem_inst_addr, 32'h40);
        wait_inst("f100");
        check("f100_pc", inst_pc, 32'h100);

        // The 0x40 line was filled: a redirect there hits without a refill
        rollback = 1'b1; rob_set_pc = 32'h40;
        @(posedge clk); #1;
        rollback = 1'b0;
        @(posedge clk); #1;
        check("hit40_rdy", {31'b0, inst_rdy}, 32'd1);
        check("hit40_pc", inst_pc, 32'h40);
        check("hit40_no_req", {31'b0, mem_inst_en}, 32'd0);

        // Reset in the middle of a refill
        rollback = 1'b1; rob_set_pc = 32'h200;
        @(posedge clk); #1;
        rollback = 1'b0;
        wait_req("req200", 32'h200);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstmid_mem_en", {31'b0, mem_inst_en}, 32'd0);
        check("rstmid_mem_addr", mem_inst_addr, 32'd0);
        check("rstmid_inst_pc", inst_pc, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("rearm_mem_en", {31'b0, mem_inst_en}, 32'd1);
        check("rearm_mem_addr", mem_inst_addr, 32'h0);
        wait_inst("refetch0");
        check("refetch0_pc", inst_pc, 32'h0);
        check("refetch0_inst", inst, 32'h0010_0093);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
